// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the multi-word sequential adder.
// Holds the FSM state encoding and the word-index width helper.
package multiword_adder_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Word index width: clog2(n), but never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/rippleadder.sv
// Plain K-bit ripple-carry adder; one full-adder cell per bit, no lookahead.
module rippleadder #(
  parameter int k = 8
) (
  input  logic [k-1:0] a,
  input  logic [k-1:0] b,
  input  logic         cin,
  output logic [k-1:0] sum,
  output logic         cout
);

  logic [k:0] carry_s;

  // Bit-serial carry chain from bit 0 upward.
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < k; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
    cout = carry_s[k];
  end

endmodule

// File: rtl/multiword_adder_seq.sv
// Wide add/subtract of K*N bits, one K-bit word per cycle through a shared
// ripple adder, least-significant word first, carry kept in a register.
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter int K = 8,
  parameter int N = 4,
  localparam int W = K * N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic [W-1:0]    ra_r;
  logic [W-1:0]    rb_r;

  logic [K-1:0]    word_a_s;
  logic [K-1:0]    word_b_s;
  logic [K-1:0]    add_sum_s;
  logic            add_cout_s;
  logic            accept_s;
  logic            last_s;
  logic            ovf_s;

  // Operand word selection and acceptance decode for the current cycle.
  always_comb begin
    word_a_s = ra_r[idx_r*K +: K];
    word_b_s = rb_r[idx_r*K +: K];
    accept_s = start && (state_r != ST_RUN);
    last_s   = (idx_r == LAST_IDX);
    // rb already holds ~b for subtraction, so this is the plain add-overflow rule.
    ovf_s    = (ra_r[W-1] == rb_r[W-1]) && (add_sum_s[K-1] != ra_r[W-1]);
  end

  rippleadder #(
    .k(K)
  ) u_adder (
    .a    (word_a_s),
    .b    (word_b_s),
    .cin  (carry_r),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Control FSM, operand capture and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      ra_r    <= '0;
      rb_r    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept_s) begin
      state_r <= ST_RUN;
      idx_r   <= '0;
      carry_r <= sub;
      ra_r    <= a;
      rb_r    <= sub ? ~b : b;
      busy    <= 1'b1;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        ST_RUN: begin
          sum[idx_r*K +: K] <= add_sum_s;
          carry_r           <= add_cout_s;
          if (last_s) begin
            cout    <= add_cout_s;
            ovf     <= ovf_s;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed self-checking bench for multiword_adder_seq (K=8, N=4).
module tb_multiword_adder_seq;

  localparam int K = 8;
  localparam int N = 4;
  localparam int W = K * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [8];

  multiword_adder_seq #(
    .K(K),
    .N(N)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present an operation at the falling edge and release start just after the accepting edge.
  task automatic launch(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic sub_i);
    @(negedge clk);
    a     = a_i;
    b     = b_i;
    sub   = sub_i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen, and the cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int seen_done;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    a      = '0;
    b      = '0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_sum",  sum,      W'(0));
    chk("reset_cout", W'(cout), W'(0));
    chk("reset_ovf",  W'(ovf),  W'(0));

    // Table-driven operations: result, flags, latency and busy length.
    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(lat, bcnt);
      chk($sformatf("vec%0d_sum", i),  sum,      vecs[i].exp_sum);
      chk($sformatf("vec%0d_cout", i), W'(cout), W'(vecs[i].exp_cout));
      chk($sformatf("vec%0d_ovf", i),  W'(ovf),  W'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_latency", i), W'(lat),  W'(N));
      chk($sformatf("vec%0d_busy_cycles", i), W'(bcnt), W'(N));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), W'(done), W'(0));
      chk($sformatf("vec%0d_sum_held", i), sum, vecs[i].exp_sum);
    end

    // Start pulse during RUN with different operands is ignored.
    launch(32'h000000FF, 32'h00000001, 1'b0);
    @(negedge clk);
    a     = 32'hFFFFFFFF;
    b     = 32'hFFFFFFFF;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignore_start_sum",  sum,      32'h00000100);
    chk("ignore_start_cout", W'(cout), W'(0));
    chk("ignore_start_lat",  W'(lat + 1), W'(N));
    @(posedge clk);
    #1;
    chk("ignore_start_idle", W'(busy), W'(0));

    // Start held high through DONE: second operation starts with no idle gap.
    @(negedge clk);
    a     = 32'hFFFFFFFF;
    b     = 32'h00000001;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'h12345678;
    b = 32'h11111111;
    wait_done(lat, bcnt);
    chk("b2b_first_sum",  sum,      32'h00000000);
    chk("b2b_first_cout", W'(cout), W'(1));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_no_gap_busy", W'(busy), W'(1));
    chk("b2b_no_gap_done", W'(done), W'(0));
    wait_done(lat, bcnt);
    chk("b2b_second_sum", sum,    32'h23456789);
    chk("b2b_second_lat", W'(lat), W'(N));
    @(posedge clk);
    #1;

    // Reset in the second RUN cycle aborts the operation.
    launch(32'hFFFFFFFF, 32'h00000001, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_sum",  sum,      W'(0));
    chk("abort_cout", W'(cout), W'(0));
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) seen_done++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", W'(seen_done), W'(0));
    launch(32'h12345678, 32'h11111111, 1'b0);
    wait_done(lat, bcnt);
    chk("after_abort_sum", sum,     32'h23456789);
    chk("after_abort_lat", W'(lat), W'(N));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
